// File: rtl/mem_arbiter.sv
// Merges the core's fetch and data ports onto one memory port with data-first
// priority, routing in-order responses back to their source through an ID FIFO.
module mem_arbiter #(
  parameter int unsigned Xlen      = 32,
  parameter int unsigned Ilen      = 32,
  parameter int unsigned MaskBits  = Xlen / 8,
  parameter int unsigned DepthLog2 = 2,
  parameter bit          WriteAck  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  output logic                 instmem_ready_o,
  input  logic                 instmem_valid_i,
  input  logic [Xlen-1:0]      instmem_addr_i,
  input  logic [Ilen-1:0]      instmem_wdata_i,
  input  logic [MaskBits-1:0]  instmem_wmask_i,
  output logic [Ilen-1:0]      instmem_rdata_o,
  output logic                 instmem_rvalid_o,

  output logic                 datamem_ready_o,
  input  logic                 datamem_valid_i,
  input  logic [Xlen-1:0]      datamem_addr_i,
  input  logic [Xlen-1:0]      datamem_wdata_i,
  input  logic [MaskBits-1:0]  datamem_wmask_i,
  output logic [Xlen-1:0]      datamem_rdata_o,
  output logic                 datamem_rvalid_o,

  input  logic                 mem_ready_i,
  output logic                 mem_valid_o,
  output logic [Xlen-1:0]      mem_addr_o,
  output logic [Xlen-1:0]      mem_wdata_o,
  output logic [MaskBits-1:0]  mem_wmask_o,
  input  logic [Xlen-1:0]      mem_rdata_i,
  input  logic                 mem_rvalid_i,

  output logic [DepthLog2:0]   outstanding_o,
  output logic                 err_o
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam int unsigned CntW  = DepthLog2 + 1;
  localparam int unsigned PtrW  = DepthLog2;

  localparam logic IdFetch = 1'b0;
  localparam logic IdData  = 1'b1;

  // ID FIFO storage: one bit per slot records which port issued the request
  logic [Depth-1:0] id_q, id_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             err_q, err_d;

  logic full;
  logic empty;
  logic sel_d;
  logic sel_i;
  logic d_tracked;
  logic blocked;
  logic req_valid;
  logic xfer;
  logic push;
  logic pop;
  logic head_id;

  logic unused_wmask;
  assign unused_wmask = ^instmem_wmask_i;

  // Grant: occupancy is taken from the register only, so a same-cycle pop
  // never opens a path from mem_rvalid_i to any ready or valid.
  always_comb begin
    full      = (count_q == CntW'(Depth));
    empty     = (count_q == '0);
    sel_d     = datamem_valid_i;
    sel_i     = instmem_valid_i & ~datamem_valid_i;
    d_tracked = ~(|datamem_wmask_i) | WriteAck;
    blocked   = full & (sel_d ? d_tracked : sel_i);
    req_valid = rst_ni & (sel_d | sel_i) & ~blocked;
    xfer      = req_valid & mem_ready_i;
    push      = xfer & (sel_d ? d_tracked : 1'b1);
    pop       = rst_ni & mem_rvalid_i & ~empty;
    head_id   = id_q[rd_ptr_q];
  end

  // Request mux and upstream handshakes
  always_comb begin
    mem_valid_o     = req_valid;
    mem_addr_o      = instmem_addr_i;
    mem_wdata_o     = Xlen'(instmem_wdata_i);
    mem_wmask_o     = '0;
    datamem_ready_o = 1'b0;
    instmem_ready_o = 1'b0;
    if (sel_d) begin
      mem_addr_o      = datamem_addr_i;
      mem_wdata_o     = datamem_wdata_i;
      mem_wmask_o     = datamem_wmask_i;
      datamem_ready_o = xfer;
    end else if (sel_i) begin
      instmem_ready_o = xfer;
    end
  end

  // Response routing by FIFO head; a response with nothing tracked is dropped
  always_comb begin
    instmem_rdata_o  = Ilen'(mem_rdata_i);
    datamem_rdata_o  = mem_rdata_i;
    instmem_rvalid_o = pop & (head_id == IdFetch);
    datamem_rvalid_o = pop & (head_id == IdData);
    outstanding_o    = count_q;
    err_o            = err_q;
  end

  // FIFO and error next-state
  always_comb begin
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | (mem_rvalid_i & empty);
    if (push) begin
      id_d[wr_ptr_q] = sel_d ? IdData : IdFetch;
      wr_ptr_d       = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed check of mem_arbiter, with both WriteAck settings
// running side by side on identical stimulus against a queue-based model.
module tb_mem_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic        iv, dv, mready, mrvalid;
  logic [31:0] ia, iw, da, dw, mrdata;
  logic [3:0]  im, dm;

  logic        inst_ready[2], inst_rvalid[2], data_ready[2], data_rvalid[2];
  logic        mem_valid[2], err[2];
  logic [31:0] inst_rdata[2], data_rdata[2], mem_addr[2], mem_wdata[2];
  logic [3:0]  mem_wmask[2];
  logic [2:0]  outstanding[2];

  // Instance 0 has WriteAck=0, instance 1 has WriteAck=1
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.WriteAck(g == 1)) u_dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .instmem_ready_o  (inst_ready[g]),
      .instmem_valid_i  (iv),
      .instmem_addr_i   (ia),
      .instmem_wdata_i  (iw),
      .instmem_wmask_i  (im),
      .instmem_rdata_o  (inst_rdata[g]),
      .instmem_rvalid_o (inst_rvalid[g]),
      .datamem_ready_o  (data_ready[g]),
      .datamem_valid_i  (dv),
      .datamem_addr_i   (da),
      .datamem_wdata_i  (dw),
      .datamem_wmask_i  (dm),
      .datamem_rdata_o  (data_rdata[g]),
      .datamem_rvalid_o (data_rvalid[g]),
      .mem_ready_i      (mready),
      .mem_valid_o      (mem_valid[g]),
      .mem_addr_o       (mem_addr[g]),
      .mem_wdata_o      (mem_wdata[g]),
      .mem_wmask_o      (mem_wmask[g]),
      .mem_rdata_i      (mrdata),
      .mem_rvalid_i     (mrvalid),
      .outstanding_o    (outstanding[g]),
      .err_o            (err[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Model: per instance an unbounded log of issued source IDs, consumed in order
  bit hist[2][256];
  int wr_m[2], rd_m[2];
  bit err_m[2], push_m[2], pop_m[2], pid_m[2], errev_m[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      wr_m[w] = 0; rd_m[w] = 0; err_m[w] = 1'b0;
      push_m[w] = 1'b0; pop_m[w] = 1'b0; errev_m[w] = 1'b0;
    end
  endtask

  // Predict this cycle's outputs from the current inputs and compare
  task automatic settle_check();
    #1;
    for (int w = 0; w < 2; w++) begin
      int occ;
      bit full, trk, blk, e_mv, e_ir, e_dr, e_irv, e_drv;
      logic [31:0] ea, ed;
      logic [3:0]  em;
      occ = wr_m[w] - rd_m[w];
      full = (occ == 4);
      e_mv = 0; e_ir = 0; e_dr = 0; e_irv = 0; e_drv = 0;
      push_m[w] = 0; pop_m[w] = 0; pid_m[w] = 0; errev_m[w] = 0;
      ea = ia; ed = iw; em = 4'h0;
      if (rst_ni) begin
        if (dv) begin
          trk = (dm == 4'h0) || (w == 1);
          blk = trk && full;
          e_mv = !blk;
          e_dr = !blk && mready;
          ea = da; ed = dw; em = dm;
          push_m[w] = e_dr && trk;
          pid_m[w] = 1'b1;
        end else if (iv) begin
          e_mv = !full;
          e_ir = !full && mready;
          push_m[w] = e_ir;
        end
        if (mrvalid) begin
          if (occ > 0) begin
            pop_m[w] = 1'b1;
            if (hist[w][rd_m[w] % 256]) e_drv = 1'b1;
            else e_irv = 1'b1;
          end else begin
            errev_m[w] = 1'b1;
          end
        end
        check($sformatf("irdata%0d", w), 64'(inst_rdata[w]), 64'(mrdata));
        check($sformatf("drdata%0d", w), 64'(data_rdata[w]), 64'(mrdata));
      end
      check($sformatf("mvalid%0d", w), 64'(mem_valid[w]), 64'(e_mv));
      check($sformatf("iready%0d", w), 64'(inst_ready[w]), 64'(e_ir));
      check($sformatf("dready%0d", w), 64'(data_ready[w]), 64'(e_dr));
      check($sformatf("irvalid%0d", w), 64'(inst_rvalid[w]), 64'(e_irv));
      check($sformatf("drvalid%0d", w), 64'(data_rvalid[w]), 64'(e_drv));
      check($sformatf("outst%0d", w), 64'(outstanding[w]), 64'(occ));
      check($sformatf("err%0d", w), 64'(err[w]), 64'(err_m[w]));
      if (e_mv) begin
        check($sformatf("maddr%0d", w), 64'(mem_addr[w]), 64'(ea));
        check($sformatf("mwdata%0d", w), 64'(mem_wdata[w]), 64'(ed));
        check($sformatf("mwmask%0d", w), 64'(mem_wmask[w]), 64'(em));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (!rst_ni) begin
      model_reset();
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (push_m[w]) begin
          hist[w][wr_m[w] % 256] = pid_m[w];
          wr_m[w]++;
        end
        if (pop_m[w]) rd_m[w]++;
        if (errev_m[w]) err_m[w] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  task automatic idle();
    iv = 0; dv = 0; mrvalid = 0; dm = 4'h0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    model_reset();
    cycle();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    iv = 0; ia = '0; iw = '0; im = '0;
    dv = 0; da = '0; dw = '0; dm = '0;
    mready = 1; mrvalid = 0; mrdata = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    settle_check();
    rst_ni = 1'b1;

    // Single fetch, response two cycles later
    iv = 1; ia = 32'h0; iw = 32'hDEAD_BEEF; im = 4'hF;
    settle_check();
    check("fo_iready", 64'(inst_ready[1]), 64'd1);
    check("fo_wmask", 64'(mem_wmask[1]), 64'd0);
    tick();
    iv = 0;
    settle_check();
    check("fo_outst1", 64'(outstanding[1]), 64'd1);
    tick();
    mrvalid = 1; mrdata = 32'h0000_0013;
    settle_check();
    check("fo_irvalid", 64'(inst_rvalid[1]), 64'd1);
    check("fo_irdata", 64'(inst_rdata[1]), 64'h13);
    check("fo_drvalid", 64'(data_rvalid[1]), 64'd0);
    tick();
    mrvalid = 0;
    settle_check();
    check("fo_outst0", 64'(outstanding[1]), 64'd0);
    tick();

    // Contention: load wins, fetch follows; responses route in order
    dv = 1; da = 32'h100; dm = 4'h0; iv = 1; ia = 32'h4;
    settle_check();
    check("ct_addr_load", 64'(mem_addr[1]), 64'h100);
    check("ct_iready_lo", 64'(inst_ready[1]), 64'd0);
    tick();
    dv = 0;
    settle_check();
    check("ct_addr_fetch", 64'(mem_addr[1]), 64'h4);
    tick();
    iv = 0; mrvalid = 1; mrdata = 32'hAA;
    settle_check();
    check("ct_resp_data", 64'(data_rvalid[1]), 64'd1);
    tick();
    mrdata = 32'hBB;
    settle_check();
    check("ct_resp_inst", 64'(inst_rvalid[1]), 64'd1);
    tick();
    mrvalid = 0;

    // Fill to full, then a stalled fetch and an untracked store
    iv = 1;
    for (int k = 0; k < 4; k++) begin
      ia = 32'(k * 4);
      cycle();
    end
    ia = 32'h40;
    settle_check();
    check("full_mvalid", 64'(mem_valid[1]), 64'd0);
    check("full_outst", 64'(outstanding[1]), 64'd4);
    tick();
    dv = 1; da = 32'h200; dw = 32'h1234_5678; dm = 4'hF;
    settle_check();
    check("st_wa0_accept", 64'(data_ready[0]), 64'd1);
    check("st_wa1_block", 64'(mem_valid[1]), 64'd0);
    tick();
    dv = 0; dm = 4'h0;
    settle_check();
    check("st_wa0_outst", 64'(outstanding[0]), 64'd4);
    tick();
    mrvalid = 1; mrdata = 32'h55;
    settle_check();
    check("full_no_bypass", 64'(mem_valid[1]), 64'd0);
    tick();
    mrvalid = 0;
    settle_check();
    check("full_unblock", 64'(inst_ready[1]), 64'd1);
    tick();
    iv = 0;
    mrvalid = 1;
    repeat (4) cycle();
    mrvalid = 0;

    // Acked store on the WriteAck=1 instance
    dv = 1; da = 32'h300; dw = 32'hCAFE_F00D; dm = 4'h3;
    settle_check();
    check("sa_wmask", 64'(mem_wmask[1]), 64'h3);
    tick();
    dv = 0; dm = 4'h0;
    settle_check();
    check("sa_outst1", 64'(outstanding[1]), 64'd1);
    check("sa_outst0", 64'(outstanding[0]), 64'd0);
    tick();
    mrvalid = 1;
    settle_check();
    check("sa_ack", 64'(data_rvalid[1]), 64'd1);
    tick();
    mrvalid = 0;
    cycle();

    // Randomized traffic; responses only while both instances have work in flight
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      iv = 1'($urandom_range(0, 9) < 6);
      dv = 1'($urandom_range(0, 1));
      ia = $urandom; iw = $urandom; im = 4'($urandom);
      da = $urandom; dw = $urandom;
      dm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      mready = 1'($urandom_range(0, 3) != 0);
      mrdata = $urandom;
      mrvalid = ((wr_m[0] - rd_m[0]) > 0) && ((wr_m[1] - rd_m[1]) > 0)
                && ($urandom_range(0, 9) < 4);
      cycle();
    end
    idle();
    mready = 1;

    // Stray response sets a sticky error; asynchronous reset clears mid-cycle
    apply_reset();
    mrvalid = 1;
    settle_check();
    check("er_no_irv", 64'(inst_rvalid[1]), 64'd0);
    check("er_no_drv", 64'(data_rvalid[1]), 64'd0);
    tick();
    mrvalid = 0;
    settle_check();
    check("er_set", 64'(err[1]), 64'd1);
    tick();
    repeat (3) cycle();
    iv = 1; ia = 32'h80;
    repeat (2) cycle();
    iv = 0;
    settle_check();
    check("rs_pre_outst", 64'(outstanding[1]), 64'd2);
    check("rs_pre_err", 64'(err[1]), 64'd1);
    iv = 1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("rs_async_outst", 64'(outstanding[1]), 64'd0);
    check("rs_async_err", 64'(err[1]), 64'd0);
    check("rs_async_mvalid", 64'(mem_valid[1]), 64'd0);
    check("rs_async_iready", 64'(inst_ready[1]), 64'd0);
    tick();
    rst_ni = 1'b1;
    repeat (3) cycle();
    idle();
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
